// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame shape and default bit timing.
// Used by the receiver, the transmitter and any later UART blocks.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 400;
   localparam int DATA_BITS            = 8;
   localparam int STOP_BITS            = 1;

   // Literals carry an ST_ prefix so they never collide with port names such as DATA.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous inputs; reset value is a parameter
// so idle-high lines do not look like an edge when reset is released.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments make meta and q two distinct flops; blocking would collapse them into one.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: samples the synchronized RX at mid-bit using a system-clock
// bit counter and emits one-cycle VALID / FRAME_ERR pulses.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RX,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 VALID,
   output logic                 FRAME_ERR,
   output logic                 BUSY
);

   localparam int               HALF_BIT  = CLKS_PER_BIT / 2;
   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_e          state;
   logic [CNT_W-1:0]     cnt;
   logic [2:0]           idx;
   logic [DATA_BITS-1:0] shreg;

   sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (RX),
      .q   (rx_s)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         DATA      <= '0;
         VALID     <= 1'b0;
         FRAME_ERR <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low each cycle; only the branch that fires raises them.
         VALID     <= 1'b0;
         FRAME_ERR <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (!rx_s) begin
                  state <= ST_START;
                  BUSY  <= 1'b1;
               end
            end
            ST_START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  idx <= '0;
                  if (rx_s) begin
                     state <= ST_IDLE;
                     BUSY  <= 1'b0;
                  end else begin
                     state <= ST_DATA;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt        <= '0;
                  shreg[idx] <= rx_s;
                  idx        <= idx + 3'd1;
                  if (idx == IDX_LAST) state <= ST_STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               // Leaving at mid-stop-bit leaves half a bit of slack for a back-to-back start edge.
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     DATA  <= shreg;
                     VALID <= 1'b1;
                     state <= ST_IDLE;
                     BUSY  <= 1'b0;
                  end else begin
                     FRAME_ERR <= 1'b1;
                     state     <= ST_BREAK;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_BREAK: begin
               if (rx_s) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a line-level frame model queues expected events,
// an independent monitor pops and compares each VALID / FRAME_ERR pulse.
module tb_uart_receiver;

   localparam int CPB     = 400;
   localparam int LATENCY = 3803;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         start;
   } ev_t;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int         cyc;
   int         n_total;
   int         n_bad;
   ev_t        exp_q[$];
   int         valid_cyc_q[$];
   logic [7:0] last_good;
   logic       prev_valid;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .CLK       (clk),
      .RST       (rst),
      .RX        (rx),
      .DATA      (data),
      .VALID     (valid),
      .FRAME_ERR (frame_err),
      .BUSY      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Line-level model of the transmitter: an 8N1 frame is good iff its stop bit is high.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      ev_t e;
      e.is_err = !stop;
      e.data   = stop ? b : last_good;
      e.start  = cyc;
      exp_q.push_back(e);
      if (stop) last_good = b;
      rx = 1'b0;
      wait_cycles(CPB);
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         wait_cycles(CPB);
      end
      rx = stop;
      wait_cycles(CPB);
   endtask

   // Monitor: consumes one expected event per output pulse.
   initial prev_valid = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         if (valid || frame_err) begin
            check("valid_ferr_exclusive", int'(valid & frame_err), 0);
            if (exp_q.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL unexpected_event: valid=%0b frame_err=%0b data=0x%0h, expected no event at cycle %0d",
                        valid, frame_err, data, cyc);
            end else begin
               ev_t e;
               int  lat;
               e   = exp_q.pop_front();
               lat = cyc - e.start;
               check("event_kind_is_err", int'(frame_err), int'(e.is_err));
               check("event_data", int'(data), int'(e.data));
               check("event_latency", (lat >= LATENCY - 1 && lat <= LATENCY + 1) ? LATENCY : lat, LATENCY);
            end
            if (valid) valid_cyc_q.push_back(cyc);
         end
         if (valid) check("valid_width", int'(prev_valid), 0);
      end
      prev_valid = valid;
   end

   initial begin
      #(120_000 * 10);
      $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_total   = 0;
      n_bad     = 0;
      last_good = 8'h00;
      rx        = 1'b1;
      rst       = 1'b0;

      // Reset state
      wait_cycles(3);
      check("rst_data", int'(data), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b1;
      wait_cycles(20);

      // Single good frame
      send_frame(8'hA5, 1'b1);
      wait_cycles(400);
      check("a5_data_held", int'(data), 8'hA5);
      check("a5_busy_idle", int'(busy), 0);

      // Glitch shorter than half a bit
      rx = 1'b0;
      wait_cycles(50);
      check("glitch_busy_high", int'(busy), 1);
      wait_cycles(100);
      rx = 1'b1;
      wait_cycles(100);
      check("glitch_busy_low", int'(busy), 0);
      check("glitch_data_unchanged", int'(data), int'(last_good));
      wait_cycles(300);

      // Framing error, held-low line, then recovery
      send_frame(8'h3C, 1'b0);
      wait_cycles(1600);
      check("break_busy", int'(busy), 1);
      check("break_data_unchanged", int'(data), 8'hA5);
      rx = 1'b1;
      wait_cycles(800);
      check("break_released", int'(busy), 0);
      send_frame(8'h81, 1'b1);
      wait_cycles(400);
      check("after_break_data", int'(data), 8'h81);

      // Back-to-back frames without idle gap
      valid_cyc_q.delete();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      wait_cycles(400);
      check("b2b_count", valid_cyc_q.size(), 3);
      if (valid_cyc_q.size() == 3) begin
         check("b2b_spacing_1", valid_cyc_q[1] - valid_cyc_q[0], 10 * CPB);
         check("b2b_spacing_2", valid_cyc_q[2] - valid_cyc_q[1], 10 * CPB);
      end

      // Reset during data bit 4 of an aborted frame
      rx = 1'b0;
      wait_cycles(CPB * 5);
      wait_cycles(200);
      rst = 1'b0;
      wait_cycles(5);
      check("midrst_data", int'(data), 0);
      check("midrst_valid", int'(valid), 0);
      check("midrst_frame_err", int'(frame_err), 0);
      check("midrst_busy", int'(busy), 0);
      last_good = 8'h00;
      rx = 1'b1;
      wait_cycles(10);
      rst = 1'b1;
      wait_cycles(800);
      check("midrst_no_event_data", int'(data), 0);
      send_frame(8'h7E, 1'b1);
      wait_cycles(400);
      check("midrst_next_data", int'(data), 8'h7E);

      // Continuous transmitter stream
      valid_cyc_q.delete();
      for (int i = 0; i < 6; i++) send_frame(8'hC3, 1'b1);
      wait_cycles(400);
      check("loop_count", valid_cyc_q.size(), 6);
      for (int i = 1; i < valid_cyc_q.size(); i++)
         check("loop_spacing", valid_cyc_q[i] - valid_cyc_q[i-1], 10 * CPB);

      // Randomized bytes, gaps and occasional bad stop bits
      for (int i = 0; i < 4; i++) begin
         logic [7:0] b;
         logic       stop;
         int         gap;
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         gap  = $urandom_range(1, 300);
         send_frame(b, stop);
         if (!stop) begin
            rx = 1'b1;
            gap = gap + 50;
         end
         wait_cycles(gap);
      end
      wait_cycles(400);
      check("rand_data_final", int'(data), int'(last_good));

      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage, the consumer of the transmitter's TX line in the UART link. Recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) from an asynchronous RX input. Bit timing comes from a counter on the system clock, not a divided clock. Each good byte is presented as a one-cycle VALID pulse and framing errors are flagged. Default timing matches the link rate: 250000 baud at 100 MHz, 400 CLK per bit.

## Interface
- CLKS_PER_BIT, default 400: system clocks per bit period. Legal range is 4 to 65535. HALF_BIT = floor(CLKS_PER_BIT/2).
- CLK, input, 1: system clock, rising edge.
- RST, input, 1: one clock; reset is asynchronous and active-low.
- RX, input, 1: serial line, idle high, asynchronous to CLK.
- DATA, output, 8: last correctly received byte. Held until the next good frame.
- VALID, output, 1: one-cycle pulse, DATA updated in the same cycle.
- FRAME_ERR, output, 1: one-cycle pulse when the stop bit is sampled low.
- BUSY, output, 1: high in any state other than IDLE.

## Operation
- RX passes through a two-flop synchronizer (rx_s), reset to 1. All decisions use rx_s only.
- States, with bit counter cnt (width clog2(CLKS_PER_BIT)) and bit index idx (3 bits):
  - IDLE: cnt=0. If rx_s==0, go to START.
  - START: cnt increments. At cnt==HALF_BIT-1, sample rx_s. If 0, go to DATA with cnt=0, idx=0. If 1, it is a glitch: go to IDLE with no output.
  - DATA: cnt increments and wraps at CLKS_PER_BIT-1. At the wrap, shift rx_s into bit idx of the shift register, then idx++. After idx 7 is sampled, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1: DATA <= shift register, VALID=1, go to IDLE.
    - If 0: FRAME_ERR=1, DATA unchanged, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This blocks a held-low line from being taken as repeated frames.
- Going back to IDLE at mid-stop-bit lets back-to-back frames with no idle gap be received.
- There is no backpressure. An unread DATA is overwritten by the next good frame.
- VALID and FRAME_ERR are registered and never high in the same cycle.

## Timing
- Reset values: DATA=8'h00, VALID=0, FRAME_ERR=0, BUSY=0, state=IDLE, rx_s=1, shift register=0.
- RST asserted mid-frame: everything takes its reset value immediately. The partial byte is discarded and no VALID is issued. After release, reception restarts at the next falling edge seen in IDLE.
- Synchronizer latency is 2 CLK. Define t0 as the first cycle rx_s==0 in IDLE.
  - Start check at t0+HALF_BIT.
  - Data bit k sampled at t0+HALF_BIT+(k+1)*CLKS_PER_BIT.
  - Stop bit sampled at t0+HALF_BIT+9*CLKS_PER_BIT.
  - VALID/FRAME_ERR rise 1 CLK after the stop sample.
- With CLKS_PER_BIT=400, VALID rises 3803±1 CLK after the RX start edge, including synchronizer delay.
- Baud mismatch tolerance is about ±4.5% cumulative at the stop bit.

## Structure
- Shared package uart_pkg holds:
  - state encoding: IDLE, START, DATA, STOP, BREAK
  - constant DEFAULT_CLKS_PER_BIT=400
  - frame constants DATA_BITS=8, STOP_BITS=1

  The transmitter and any future UART blocks use the same package.
- One sub-module: sync_2ff, a 1-bit two-flop synchronizer with reset value a parameter (1 here). It is reused for other asynchronous inputs.
- Everything else (FSM, counter, shift register, output registers) lives in uart_receiver. Expected size is about 150 to 200 lines.

## Test plan
- Single frame 8'hA5 at 400 CLK/bit, then idle high:
  - exactly one VALID pulse, 1 cycle wide, DATA=8'hA5, FRAME_ERR never high
  - VALID 3803±1 CLK after the start edge
- Glitch: RX low for 150 CLK, then high (shorter than HALF_BIT=200):
  - BUSY rises, then drops back
  - no VALID, no FRAME_ERR, DATA unchanged
- Framing error: byte 8'h3C sent with stop bit 0, line held low 2000 CLK, then high, then a good 8'h81:
  - one FRAME_ERR pulse, DATA stays at the previous value
  - no further events while low
  - then VALID with DATA=8'h81
- Back-to-back frames 8'h00, 8'hFF, 8'h55 with no idle gap:
  - three VALID pulses exactly 10*400 CLK apart, with the matching DATA values
- Reset mid-frame: RST low during data bit 4, released, then frame 8'h7E:
  - all outputs reset while RST is low
  - no VALID for the aborted frame
  - next VALID carries DATA=8'h7E
- Loopback: transmitter TX driven into RX, transmitter DATA=8'hC3:
  - continuous VALID every 4000 CLK with DATA=8'hC3 and zero FRAME_ERR over 20 frames
